// File: rtl/ddr_rdata_return.sv
// ddr_rdata_return
//   Read-data return stage on the bus side of the DDR read path. Bursts of
//   BURST_WORDS words are drained from the RDATA async FIFO into a line
//   buffer, then the requested words are returned in wrap order starting at
//   the critical word. Requests are queued in issue order; each burst read
//   from the FIFO belongs to the oldest outstanding request.
//   Everything runs in the FIFO read-clock domain.
//
// Ports
//   clk, reset            read clock, async active-high reset
//   req_valid/req_ready   request handshake; req_word = critical word,
//                         req_cnt = words to return minus 1
//   rfifo_empty/rfifo_next/rfifo_dout
//                         FIFO read port; dout valid the cycle after a pop
//   rd_valid/rd_ready     return stream handshake; rd_data, rd_last
//   err_orphan            sticky: a FIFO word arrived with nothing queued
module ddr_rdata_return #(
  parameter int BURST_WORDS = 4,
  parameter int REQ_DEPTH   = 4,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_word,
  input  logic [1:0]    req_cnt,
  input  logic          rfifo_empty,
  input  logic [DW-1:0] rfifo_dout,
  output logic          rfifo_next,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          err_orphan
);

  localparam int QAW = $clog2(REQ_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RET} state_t;

  state_t        r_state;
  logic [1:0]    r_q_word [REQ_DEPTH];
  logic [1:0]    r_q_cnt  [REQ_DEPTH];
  logic [QAW-1:0] r_wp, r_rp;
  logic [QAW:0]  r_qn;
  logic [2:0]    r_pop_cnt, r_cap_cnt;
  logic          r_cap;
  logic [1:0]    r_idx;
  logic [DW-1:0] r_line [BURST_WORDS];
  logic          r_err;

  logic          w_push, w_pop, w_hs;
  logic [QAW:0]  w_qn_nxt;
  logic [1:0]    w_head_word, w_head_cnt, w_ridx;

  assign req_ready   = (r_qn != (QAW+1)'(REQ_DEPTH));
  assign w_push      = req_valid && req_ready;
  assign w_hs        = rd_valid && rd_ready;
  assign w_pop       = w_hs && rd_last;
  assign w_qn_nxt    = r_qn + (QAW+1)'(w_push) - (QAW+1)'(w_pop);
  assign w_head_word = r_q_word[r_rp];
  assign w_head_cnt  = r_q_cnt[r_rp];
  assign w_ridx      = w_head_word + r_idx;   // 2-bit add wraps within the burst

  // Pops are gated by rfifo_empty combinationally so a pop can never be
  // issued against an empty FIFO. In IDLE with nothing queued, any word that
  // shows up is an orphan and is drained so it cannot misalign later bursts.
  assign rfifo_next = !rfifo_empty &&
                      (((r_state == S_FILL) && (r_pop_cnt < 3'(BURST_WORDS))) ||
                       ((r_state == S_IDLE) && (r_qn == '0)));

  assign rd_valid   = (r_state == S_RET);
  assign rd_data    = rd_valid ? r_line[w_ridx] : '0;
  assign rd_last    = rd_valid && (r_idx == w_head_cnt);
  assign err_orphan = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_wp      <= '0;
      r_rp      <= '0;
      r_qn      <= '0;
      r_pop_cnt <= '0;
      r_cap_cnt <= '0;
      r_cap     <= 1'b0;
      r_idx     <= '0;
      r_err     <= 1'b0;
      for (int i = 0; i < REQ_DEPTH; i++) begin
        r_q_word[i] <= '0;
        r_q_cnt[i]  <= '0;
      end
      for (int i = 0; i < BURST_WORDS; i++) r_line[i] <= '0;
    end else begin
      // request queue
      if (w_push) begin
        r_q_word[r_wp] <= req_word;
        r_q_cnt[r_wp]  <= req_cnt;
        r_wp           <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_qn <= w_qn_nxt;

      // registered read port: data for a FILL pop lands one cycle later
      r_cap <= rfifo_next && (r_state == S_FILL);

      case (r_state)
        S_IDLE: begin
          if (r_qn != '0) begin
            r_state   <= S_FILL;
            r_pop_cnt <= '0;
            r_cap_cnt <= '0;
          end else if (rfifo_next) begin
            r_err <= 1'b1;
          end
        end
        S_FILL: begin
          if (rfifo_next) r_pop_cnt <= r_pop_cnt + 1'b1;
          if (r_cap) begin
            r_line[r_cap_cnt[1:0]] <= rfifo_dout;
            r_cap_cnt              <= r_cap_cnt + 1'b1;
            if (r_cap_cnt == 3'(BURST_WORDS - 1)) begin
              r_state <= S_RET;
              r_idx   <= '0;
            end
          end
        end
        S_RET: begin
          if (w_hs) begin
            r_idx <= r_idx + 1'b1;
            if (rd_last) begin
              // a request pushed this same cycle counts toward going back to FILL
              if (w_qn_nxt != '0) begin
                r_state   <= S_FILL;
                r_pop_cnt <= '0;
                r_cap_cnt <= '0;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_rdata_return.sv
module tb_ddr_rdata_return;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_word, req_cnt;
  logic        rfifo_empty;
  logic [31:0] rfifo_dout = '0;
  logic        rfifo_next;
  logic        rd_valid, rd_ready, rd_last, err_orphan;
  logic [31:0] rd_data;

  ddr_rdata_return #(.BURST_WORDS(4), .REQ_DEPTH(4), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_word(req_word), .req_cnt(req_cnt),
    .rfifo_empty(rfifo_empty), .rfifo_dout(rfifo_dout), .rfifo_next(rfifo_next),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  // RDATA FIFO model with registered read port and optional gapping
  logic [31:0] mem [0:1023];
  int          f_wr = 0, f_rd = 0;
  logic        gap = 1'b0, gap_en = 1'b0;
  assign rfifo_empty = (f_wr == f_rd) || gap;

  always @(posedge clk) begin
    gap <= gap_en ? ~gap : 1'b0;
    if (rfifo_next && !rfifo_empty) begin
      rfifo_dout <= mem[f_rd];
      f_rd       <= f_rd + 1;
    end
  end

  // monitors
  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] hs_data [0:255];
  logic        hs_last [0:255];
  int          hs_cyc  [0:255];
  int          hs_n = 0;
  int          pop_cyc [0:255];
  int          pop_n = 0;
  int          viol = 0;
  int          rdy_rise_cyc = -1, orph_rise_cyc = -1;
  logic        prev_rdy = 1'b1, prev_err = 1'b0;

  always @(negedge clk) begin
    if (rfifo_next && rfifo_empty) viol++;
    if (rfifo_next) begin pop_cyc[pop_n] = cyc; pop_n++; end
    if (rd_valid && rd_ready) begin
      hs_data[hs_n] = rd_data; hs_last[hs_n] = rd_last; hs_cyc[hs_n] = cyc; hs_n++;
    end
    if (req_ready && !prev_rdy) rdy_rise_cyc = cyc;
    if (err_orphan && !prev_err) orph_rise_cyc = cyc;
    prev_rdy = req_ready;
    prev_err = err_orphan;
  end

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic pclk; @(posedge clk); #1; endtask
  task automatic nclk; @(negedge clk); #1; endtask

  task automatic load4(input logic [31:0] b);
    for (int i = 0; i < 4; i++) mem[f_wr + i] = b + i;
    f_wr = f_wr + 4;
  endtask

  task automatic push_req(input logic [1:0] w, input logic [1:0] c);
    req_valid = 1'b1; req_word = w; req_cnt = c;
    pclk;
    req_valid = 1'b0;
  endtask

  task automatic wait_hs(input string tag, input int n, input int budget);
    int k = 0;
    while (hs_n < n && k < budget) begin nclk; k++; end
    repeat (4) nclk;
    chk(tag, hs_n, n);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    nclk;
    while (!rd_valid && k < 60) begin nclk; k++; end
    chk(tag, rd_valid, 1);
  endtask

  task automatic chk_hs(input string tag, input int i, input logic [31:0] d, input logic l);
    chk({tag, "_data"}, hs_data[i], d);
    chk({tag, "_last"}, hs_last[i], l);
  endtask

  int hb, pb;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_word = '0; req_cnt = '0; rd_ready = 1'b1;
    repeat (2) pclk;
    nclk;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rfifo_next", rfifo_next, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_err", err_orphan, 0);
    pclk; reset = 1'b0;
    repeat (2) pclk;

    // 1: linear burst, full return, latency
    hb = hs_n; pb = pop_n;
    push_req(2'd0, 2'd3);
    load4(32'hA000_0000);
    wait_hs("t1_count", hb + 4, 40);
    chk_hs("t1_w0", hb + 0, 32'hA000_0000, 0);
    chk_hs("t1_w1", hb + 1, 32'hA000_0001, 0);
    chk_hs("t1_w2", hb + 2, 32'hA000_0002, 0);
    chk_hs("t1_w3", hb + 3, 32'hA000_0003, 1);
    chk("t1_back2back", hs_cyc[hb + 3] - hs_cyc[hb], 3);
    chk("t1_latency", hs_cyc[hb] - pop_cyc[pb], 5);
    chk("t1_pops", pop_n - pb, 4);

    // 2: wrap order
    hb = hs_n;
    push_req(2'd2, 2'd3);
    load4(32'hB000_0000);
    wait_hs("t2_count", hb + 4, 40);
    chk_hs("t2_w0", hb + 0, 32'hB000_0002, 0);
    chk_hs("t2_w1", hb + 1, 32'hB000_0003, 0);
    chk_hs("t2_w2", hb + 2, 32'hB000_0000, 0);
    chk_hs("t2_w3", hb + 3, 32'hB000_0001, 1);

    // 3: partial return then next burst matched to next request
    hb = hs_n; pb = pop_n;
    push_req(2'd3, 2'd0);
    push_req(2'd1, 2'd2);
    load4(32'hC000_0000);
    load4(32'hD000_0000);
    wait_hs("t3_count", hb + 4, 60);
    chk_hs("t3_c3", hb + 0, 32'hC000_0003, 1);
    chk_hs("t3_d1", hb + 1, 32'hD000_0001, 0);
    chk_hs("t3_d2", hb + 2, 32'hD000_0002, 0);
    chk_hs("t3_d3", hb + 3, 32'hD000_0003, 1);
    chk("t3_pops", pop_n - pb, 8);

    // 4: queue full, issue order, req_ready recovery
    hb = hs_n;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_word = 2'(i); req_cnt = 2'd0;
      pclk;
    end
    req_valid = 1'b0;
    nclk;
    chk("t4_full", req_ready, 0);
    pclk;
    for (int i = 0; i < 4; i++) load4(32'hE000_0000 + 32'(4 * i));
    wait_hs("t4_count", hb + 4, 100);
    chk_hs("t4_r0", hb + 0, 32'hE000_0000, 1);
    chk_hs("t4_r1", hb + 1, 32'hE000_0005, 1);
    chk_hs("t4_r2", hb + 2, 32'hE000_000A, 1);
    chk_hs("t4_r3", hb + 3, 32'hE000_000F, 1);
    chk("t4_rdy_rise", rdy_rise_cyc, hs_cyc[hb] + 1);

    // 5: gapped FIFO and backpressure
    hb = hs_n;
    rd_ready = 1'b0; gap_en = 1'b1;
    push_req(2'd1, 2'd3);
    load4(32'h6000_0000);
    wait_valid("t5_valid");
    chk("t5_hold0", rd_data, 32'h6000_0001);
    nclk;
    chk("t5_hold1", rd_data, 32'h6000_0001);
    nclk;
    chk("t5_hold2", rd_data, 32'h6000_0001);
    chk("t5_hold_last", rd_last, 0);
    pclk; rd_ready = 1'b1;
    wait_hs("t5_count", hb + 4, 40);
    chk_hs("t5_w0", hb + 0, 32'h6000_0001, 0);
    chk_hs("t5_w1", hb + 1, 32'h6000_0002, 0);
    chk_hs("t5_w2", hb + 2, 32'h6000_0003, 0);
    chk_hs("t5_w3", hb + 3, 32'h6000_0000, 1);
    gap_en = 1'b0;
    chk("t5_no_pop_empty", viol, 0);

    // 6: orphan word
    pb = pop_n;
    pclk;
    mem[f_wr] = 32'h0BAD_0BAD; f_wr = f_wr + 1;
    repeat (3) nclk;
    chk("t6_orphan", err_orphan, 1);
    chk("t6_orphan_pops", pop_n - pb, 1);
    chk("t6_orphan_time", orph_rise_cyc, pop_cyc[pb] + 1);
    chk("t6_fifo_drained", f_rd, f_wr);

    // 7: reset mid-RETURN, then normal service
    rd_ready = 1'b0;
    push_req(2'd0, 2'd3);
    load4(32'h7000_0000);
    wait_valid("t7_valid");
    pclk; reset = 1'b1;
    nclk;
    chk("t7_rd_valid", rd_valid, 0);
    chk("t7_rd_data", rd_data, 0);
    chk("t7_rd_last", rd_last, 0);
    chk("t7_rfifo_next", rfifo_next, 0);
    chk("t7_err", err_orphan, 0);
    chk("t7_req_ready", req_ready, 1);
    pclk; reset = 1'b0;
    pclk;
    hb = hs_n;
    rd_ready = 1'b1;
    push_req(2'd2, 2'd1);
    load4(32'h8000_0000);
    wait_hs("t7_count", hb + 2, 40);
    chk_hs("t7_w0", hb + 0, 32'h8000_0002, 0);
    chk_hs("t7_w1", hb + 1, 32'h8000_0003, 1);
    chk("t7_err_after", err_orphan, 0);
    chk("t7_no_pop_empty", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
